memory_reader: RTL and testbench



---
 rtl/memory_reader.sv | 127 ++++++++++++
 tb/tb_memory_reader.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_reader.sv
// memory_reader: turns a (start address, length) burst command into memory reads.
// The returned words leave in order through a 2-entry FIFO, with a last-word flag on the final one.
`default_nettype none

module memory_reader #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_stb,
  input  logic [AW-1:0]    cmd_addr,
  input  logic [AW:0]      cmd_len,
  output logic             cmd_rdy,
  output logic             ar_stb,
  output logic [AW-1:0]    ar_dat,
  input  logic             ar_rdy,
  input  logic             r_stb,
  input  logic [WIDTH-1:0] r_dat,
  output logic             r_rdy,
  output logic             out_stb,
  output logic [WIDTH-1:0] out_dat,
  output logic             out_last,
  input  logic             out_rdy,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);

  state_t           state;
  logic [AW-1:0]    addr;
  logic [AW:0]      issue_cnt;
  logic [AW:0]      resp_cnt;
  logic [WIDTH-1:0] fifo_dat [2];
  logic [1:0]       fifo_last;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;

  logic fifo_full;
  logic push;
  logic pop;

  assign fifo_full = count[1];
  assign push      = r_stb & r_rdy;
  assign pop       = out_stb & out_rdy;

  assign cmd_rdy  = (state == IDLE);
  assign busy     = (state != IDLE);
  assign ar_stb   = (state == ISSUE);
  assign ar_dat   = addr;
  // IDLE refuses responses so nothing stale from before a reset can enter the FIFO.
  assign r_rdy    = (state != IDLE) & ~fifo_full;
  assign out_stb  = (count != 2'd0);
  assign out_dat  = fifo_dat[rd_ptr];
  assign out_last = fifo_last[rd_ptr] & out_stb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      addr        <= '0;
      issue_cnt   <= '0;
      resp_cnt    <= '0;
      fifo_dat[0] <= '0;
      fifo_dat[1] <= '0;
      fifo_last   <= '0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      count       <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_stb && (cmd_len != '0)) begin
            addr      <= cmd_addr;
            issue_cnt <= cmd_len;
            resp_cnt  <= cmd_len;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (ar_rdy) begin
            addr      <= (addr == ADDR_MAX) ? '0 : addr + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
            if (issue_cnt == CNT_ONE) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        fifo_dat[wr_ptr]  <= r_dat;
        fifo_last[wr_ptr] <= (resp_cnt == CNT_ONE);
        wr_ptr            <= ~wr_ptr;
        resp_cnt          <= resp_cnt - 1'b1;
      end

      // The final word can only leave after every address went out, so this never races ISSUE.
      if (pop) begin
        rd_ptr <= ~rd_ptr;
        if (out_last) begin
          state <= IDLE;
        end
      end

      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_reader.sv
// tb_memory_reader: directed table of bursts plus random bursts against a queue-based reference.
`default_nettype none

module tb_memory_reader;

  localparam int WIDTH = 16;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_stb;
  logic [AW-1:0]    cmd_addr;
  logic [AW:0]      cmd_len;
  logic             cmd_rdy;
  logic             ar_stb;
  logic [AW-1:0]    ar_dat;
  logic             ar_rdy;
  logic             r_stb;
  logic [WIDTH-1:0] r_dat;
  logic             r_rdy;
  logic             out_stb;
  logic [WIDTH-1:0] out_dat;
  logic             out_last;
  logic             out_rdy;
  logic             busy;
  logic             ar_gate;

  logic [WIDTH-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .cmd_stb(cmd_stb), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_rdy(cmd_rdy),
    .ar_stb(ar_stb), .ar_dat(ar_dat), .ar_rdy(ar_rdy),
    .r_stb(r_stb), .r_dat(r_dat), .r_rdy(r_rdy),
    .out_stb(out_stb), .out_dat(out_dat), .out_last(out_last), .out_rdy(out_rdy),
    .busy(busy)
  );

  // One-cycle read latency memory with a single response slot.
  assign ar_rdy = (!r_stb || r_rdy) && ar_gate;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stb <= 1'b0;
      r_dat <= '0;
    end else if (ar_stb && ar_rdy) begin
      r_stb <= 1'b1;
      r_dat <= mem[ar_dat];
    end else if (r_rdy) begin
      r_stb <= 1'b0;
    end
  end

  typedef struct {
    logic [7:0]  addr;
    logic [8:0]  len;
    int          rdy_pct;
    logic [15:0] exp_first;
    logic [15:0] exp_last;
    int          exp_idle;   // -1 when timing is not checked
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_burst(input logic [7:0] a, input logic [8:0] len, input int rdy_pct,
                           input int ar_pct, output logic [15:0] first_w,
                           output logic [15:0] last_w, output int idle_cyc);
    logic [15:0] exp_q[$];
    logic [7:0]  addr_q[$];
    logic [15:0] w;
    logic [15:0] hold_d;
    logic        hold_l;
    logic        stall;
    bit          timed;
    bit          seen_ar;
    bit          seen_out;
    int          occ;
    int          nbeats;
    int          budget;
    timed    = (rdy_pct >= 100) && (ar_pct >= 100);
    seen_ar  = 0;
    seen_out = 0;
    first_w  = '0;
    last_w   = '0;
    idle_cyc = -1;
    occ      = 0;
    nbeats   = 0;
    stall    = 1'b0;
    hold_d   = '0;
    hold_l   = 1'b0;
    budget   = 30 * int'(len) + 100;
    for (int i = 0; i < int'(len); i++) begin
      addr_q.push_back(8'((int'(a) + i) % DEPTH));
      exp_q.push_back(mem[(int'(a) + i) % DEPTH]);
    end
    @(posedge clk); #1;
    cmd_stb  = 1'b1;
    cmd_addr = a;
    cmd_len  = len;
    out_rdy  = ($urandom_range(99) < rdy_pct);
    ar_gate  = ($urandom_range(99) < ar_pct);
    @(negedge clk);
    check("cmd_rdy_idle", {31'd0, cmd_rdy}, 32'd1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (ar_stb && ar_rdy) begin
        if (addr_q.size() == 0) check("ar_extra", 32'd1, 32'd0);
        else check("ar_dat", {24'd0, ar_dat}, {24'd0, addr_q.pop_front()});
        if (timed && !seen_ar) check("first_ar_cycle", cyc, 32'd1);
        seen_ar = 1;
      end
      if (stall) begin
        check("hold_stb", {31'd0, out_stb}, 32'd1);
        check("hold_dat", {16'd0, out_dat}, {16'd0, hold_d});
        check("hold_last", {31'd0, out_last}, {31'd0, hold_l});
      end
      if (occ == 2) check("r_rdy_full", {31'd0, r_rdy}, 32'd0);
      if (out_stb && out_rdy) begin
        if (exp_q.size() == 0) begin
          check("out_extra", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("out_dat", {16'd0, out_dat}, {16'd0, w});
          check("out_last", {31'd0, out_last}, {31'd0, exp_q.size() == 0});
          if (!seen_out) begin
            first_w = out_dat;
            if (timed) check("first_out_cycle", cyc, 32'd3);
          end
          seen_out = 1;
          last_w = out_dat;
          nbeats++;
        end
      end
      occ   = occ + int'(r_stb && r_rdy) - int'(out_stb && out_rdy);
      stall = out_stb && !out_rdy;
      hold_d = out_dat;
      hold_l = out_last;
      @(posedge clk); #1;
      cmd_stb = 1'b0;
      out_rdy = ($urandom_range(99) < rdy_pct);
      ar_gate = ($urandom_range(99) < ar_pct);
      @(negedge clk);
      if (cmd_rdy && exp_q.size() == 0) begin
        idle_cyc = cyc + 1;
        break;
      end
    end
    if (idle_cyc < 0) check("burst_timeout", 32'd0, 32'd1);
    check("beat_count", nbeats, {23'd0, len});
  endtask

  task automatic zero_len(input logic [7:0] a);
    @(posedge clk); #1;
    cmd_stb  = 1'b1;
    cmd_addr = a;
    cmd_len  = '0;
    @(posedge clk); #1;
    cmd_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zl_ar_stb", {31'd0, ar_stb}, 32'd0);
      check("zl_out_stb", {31'd0, out_stb}, 32'd0);
      check("zl_busy", {31'd0, busy}, 32'd0);
      check("zl_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_ar_stb", {31'd0, ar_stb}, 32'd0);
    check("rst_r_rdy", {31'd0, r_rdy}, 32'd0);
    check("rst_out_stb", {31'd0, out_stb}, 32'd0);
    check("rst_out_last", {31'd0, out_last}, 32'd0);
    check("rst_out_dat", {16'd0, out_dat}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_rdy", {31'd0, cmd_rdy}, 32'd1);
  endtask

  initial begin
    logic [15:0] fw;
    logic [15:0] lw;
    int          idle;
    int          beats;
    logic [7:0]  ra;
    logic [8:0]  rl;
    int          rp;
    int          ap;

    vecs[0] = '{8'h10, 9'd4,   100, 16'h0030, 16'h0039, 7};
    vecs[1] = '{8'hFE, 9'd4,   100, 16'h02FA, 16'h0003, 7};
    vecs[2] = '{8'h20, 9'd16,  50,  16'h0060, 16'h008D, -1};
    vecs[3] = '{8'h00, 9'd256, 100, 16'h0000, 16'h02FD, 259};

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(3 * i);
    rst      = 1'b0;
    cmd_stb  = 1'b0;
    cmd_addr = '0;
    cmd_len  = '0;
    out_rdy  = 1'b1;
    ar_gate  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals();
    rst = 1'b1;

    foreach (vecs[k]) begin
      run_burst(vecs[k].addr, vecs[k].len, vecs[k].rdy_pct, 100, fw, lw, idle);
      check("vec_first", {16'd0, fw}, {16'd0, vecs[k].exp_first});
      check("vec_last", {16'd0, lw}, {16'd0, vecs[k].exp_last});
      if (vecs[k].exp_idle >= 0) check("vec_idle_cycle", idle, vecs[k].exp_idle);
    end

    zero_len(8'h33);

    // Reset in the middle of a burst, right after the second beat is taken.
    @(posedge clk); #1;
    cmd_stb  = 1'b1;
    cmd_addr = 8'h00;
    cmd_len  = 9'd8;
    out_rdy  = 1'b1;
    ar_gate  = 1'b1;
    @(posedge clk); #1;
    cmd_stb = 1'b0;
    beats = 0;
    for (int i = 0; i < 50 && beats < 2; i++) begin
      @(negedge clk);
      if (out_stb && out_rdy) beats++;
    end
    check("mid_rst_beats", beats, 32'd2);
    #2 rst = 1'b0;
    #1 check_reset_vals();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_burst(8'h40, 9'd2, 100, 100, fw, lw, idle);
    check("post_rst_first", {16'd0, fw}, 32'h00C0);
    check("post_rst_last", {16'd0, lw}, 32'h00C3);
    check("post_rst_idle", idle, 32'd5);

    for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
    for (int n = 0; n < 16; n++) begin
      ra = 8'($urandom_range(255));
      rl = ($urandom_range(7) == 0) ? 9'd0 : 9'($urandom_range(1, 40));
      rp = ($urandom_range(3) == 0) ? 100 : int'($urandom_range(30, 90));
      ap = ($urandom_range(2) == 0) ? 100 : int'($urandom_range(40, 90));
      if (rl == 0) begin
        zero_len(ra);
      end else begin
        run_burst(ra, rl, rp, ap, fw, lw, idle);
        if (rp == 100 && ap == 100) check("rand_idle_cycle", idle, 3 + int'(rl));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
